// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with packet-atomic switching and
// round-robin / fixed-priority / forced channel selection.
//
// state  | meaning
// IDLE   | grant recomputed every cycle from force/MODE arbitration
// LOCKED | grant frozen on lock_ch until its in_last beat transfers
module stream_mux_rr #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int MODE   = 0,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH-1:0]       in_last,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    force_en,
    input  logic [SEL_W-1:0]        force_sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] rr_ptr, lock_ch, arb_idx, grant;
    logic             arb_found, arb_ok, load, xfer;
    logic             sel_valid, sel_last;
    logic [WIDTH-1:0] sel_data;
    int               idx;

    assign load = ~out_valid | out_ready;

    always_comb begin : arbitrate
        arb_idx   = '0;
        arb_found = 1'b0;
        idx       = 0;
        if (force_en) begin
            // An out-of-range force_sel matches no channel, so nothing is granted.
            for (int i = 0; i < NUM_CH; i++) begin
                if (force_sel == SEL_W'(i)) begin
                    arb_idx   = SEL_W'(i);
                    arb_found = in_valid[i];
                end
            end
        end else if (MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    arb_idx   = SEL_W'(i);
                    arb_found = 1'b1;
                end
            end
        end else begin
            // Scan downward so the candidate closest to rr_ptr is written last.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_CH) idx = idx - NUM_CH;
                if (in_valid[idx]) begin
                    arb_idx   = SEL_W'(idx);
                    arb_found = 1'b1;
                end
            end
        end
    end

    always_comb begin : grant_mux
        grant     = (state == LOCKED) ? lock_ch : arb_idx;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
                sel_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
        arb_ok = (state == LOCKED) ? sel_valid : arb_found;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = rst_n & load & arb_ok & (grant == SEL_W'(i));
        end
    end

    assign xfer = |(in_valid & in_ready);

    always_comb begin : fsm_next
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && !sel_last) state_nxt = LOCKED;
            LOCKED:  if (xfer && sel_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lock_ch <= '0;
            rr_ptr  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && xfer) lock_ch <= grant;
            if (xfer && sel_last && MODE == 0 && !force_en)
                rr_ptr <= (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= sel_data;
                out_last <= sel_last;
                out_sel  <= grant;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a round-robin instance (4 ch) and a
// fixed-priority instance (3 ch, so an out-of-range force_sel is expressible).
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_last;
    logic        force_en;
    logic [1:0]  force_sel;
    logic        out_ready;

    logic [3:0]  rr_in_ready;
    logic [7:0]  rr_out_data;
    logic        rr_out_valid, rr_out_last;
    logic [1:0]  rr_out_sel;

    logic [2:0]  fp_in_ready;
    logic [7:0]  fp_out_data;
    logic        fp_out_valid, fp_out_last;
    logic [1:0]  fp_out_sel;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(8), .NUM_CH(4), .MODE(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(rr_in_ready),
        .force_en(force_en), .force_sel(force_sel),
        .out_data(rr_out_data), .out_valid(rr_out_valid),
        .out_last(rr_out_last), .out_sel(rr_out_sel),
        .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(8), .NUM_CH(3), .MODE(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_last(in_last[2:0]),
        .in_ready(fp_in_ready),
        .force_en(force_en), .force_sel(force_sel),
        .out_data(fp_out_data), .out_valid(fp_out_valid),
        .out_last(fp_out_last), .out_sel(fp_out_sel),
        .out_ready(out_ready)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      q[$];
    int         checks   = 0;
    int         failures = 0;
    int         seq      = 0;
    logic       use_fp   = 1'b0;
    logic       auto_d   = 1'b1;
    logic [7:0] d[4];

    logic [3:0] obs_ready;
    logic       obs_valid;
    beat_t      obs_beat;

    assign in_data   = {d[3], d[2], d[1], d[0]};
    assign obs_ready = use_fp ? {1'b0, fp_in_ready} : rr_in_ready;
    assign obs_valid = use_fp ? fp_out_valid : rr_out_valid;
    assign obs_beat  = use_fp ? {fp_out_sel, fp_out_data, fp_out_last}
                              : {rr_out_sel, rr_out_data, rr_out_last};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check ready and output against the
    // scoreboard, retire the output beat if consumed, record the accepted input.
    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                       input logic [3:0] er, input string tag);
        beat_t b;
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        if (auto_d) begin
            for (int i = 0; i < 4; i++) d[i] = 8'(i * 16 + (seq % 16));
        end
        seq++;
        #3;
        chk({tag, "_rdy"}, 16'(obs_ready), 16'(er));
        chk({tag, "_vld"}, 16'(obs_valid), 16'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, "_beat"}, 16'(obs_beat), 16'(q[0]));
            if (ordy) void'(q.pop_front());
        end
        if (er != 4'b0000) begin
            b = '0;
            for (int i = 0; i < 4; i++) begin
                if (er[i]) begin
                    b.sel  = 2'(i);
                    b.data = d[i];
                    b.last = l[i];
                end
            end
            q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        in_last   = 4'h0;
        force_en  = 1'b0;
        force_sel = 2'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;

        // Held in reset with every channel valid
        cyc(4'hF, 4'hF, 1'b1, 4'b0000, "rst_a");
        cyc(4'hF, 4'hF, 1'b1, 4'b0000, "rst_b");
        chk("rst_out", 16'(obs_beat), 16'h0000);
        rst_n = 1'b1;

        // Round-robin fairness, single-beat packets
        cyc(4'hF, 4'hF, 1'b1, 4'b0001, "rr0");
        cyc(4'hF, 4'hF, 1'b1, 4'b0010, "rr1");
        cyc(4'hF, 4'hF, 1'b1, 4'b0100, "rr2");
        cyc(4'hF, 4'hF, 1'b1, 4'b1000, "rr3");
        cyc(4'hF, 4'hF, 1'b1, 4'b0001, "rr4");
        cyc(4'hF, 4'hF, 1'b1, 4'b0010, "rr5");
        cyc(4'h0, 4'h0, 1'b1, 4'b0000, "rr_drain");

        // Packet lock on ch2 with ch0 always valid, including a gap
        cyc(4'b0101, 4'b0001, 1'b1, 4'b0100, "lock_b1");
        cyc(4'b0101, 4'b0001, 1'b1, 4'b0100, "lock_b2");
        cyc(4'b0001, 4'b0001, 1'b1, 4'b0000, "lock_gap");
        cyc(4'b0101, 4'b0101, 1'b1, 4'b0100, "lock_b3");
        cyc(4'b0001, 4'b0001, 1'b1, 4'b0001, "lock_rel");
        cyc(4'h0, 4'h0, 1'b1, 4'b0000, "lock_drain");

        // Wrap-around from rr_ptr=3 with only ch0 and ch2 valid
        cyc(4'b0100, 4'b0100, 1'b1, 4'b0100, "wrap_ch2");
        cyc(4'b0101, 4'b0101, 1'b1, 4'b0001, "wrap_ch0");
        cyc(4'b0101, 4'b0101, 1'b1, 4'b0100, "wrap_ch2b");
        cyc(4'b0101, 4'b0101, 1'b1, 4'b0001, "wrap_ch0b");
        cyc(4'h0, 4'h0, 1'b1, 4'b0000, "wrap_drain");

        // Backpressure with 8'hA5 held in the output register
        auto_d = 1'b0;
        d[0] = 8'h11; d[1] = 8'hA5; d[2] = 8'h22; d[3] = 8'h33;
        cyc(4'b0010, 4'b0010, 1'b1, 4'b0010, "bp_load");
        d[1] = 8'h5A;
        for (int n = 0; n < 5; n++) cyc(4'hF, 4'hF, 1'b0, 4'b0000, "bp_stall");
        cyc(4'hF, 4'hF, 1'b1, 4'b0100, "bp_release");
        cyc(4'h0, 4'h0, 1'b1, 4'b0000, "bp_drain");
        cyc(4'h0, 4'h0, 1'b1, 4'b0000, "bp_empty");
        auto_d = 1'b1;

        // Reset mid-packet with a valid beat in the output register
        cyc(4'b1000, 4'b0000, 1'b1, 4'b1000, "mid_lock");
        chk("mid_pre_vld", 16'(obs_valid), 16'h0001);
        in_valid = 4'hF;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_vld", 16'(obs_valid), 16'h0000);
        chk("mid_rst_out", 16'(obs_beat), 16'h0000);
        chk("mid_rst_rdy", 16'(obs_ready), 16'h0000);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b0100, 4'b0100, 1'b1, 4'b0100, "post_rst");
        cyc(4'h0, 4'h0, 1'b1, 4'b0000, "post_rst_out");

        // Fixed-priority instance: priority, force, lock vs force change, out-of-range
        rst_n  = 1'b0;
        use_fp = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(4'b0110, 4'b0110, 1'b1, 4'b0010, "fp_pri1");
        cyc(4'b0110, 4'b0110, 1'b1, 4'b0010, "fp_pri2");
        force_en  = 1'b1;
        force_sel = 2'd2;
        cyc(4'b0110, 4'b0010, 1'b1, 4'b0100, "fp_frc_b1");
        force_sel = 2'd1;
        cyc(4'b0110, 4'b0010, 1'b1, 4'b0100, "fp_lock_b2");
        cyc(4'b0110, 4'b0110, 1'b1, 4'b0100, "fp_lock_b3");
        cyc(4'b0110, 4'b0110, 1'b1, 4'b0010, "fp_frc1");
        force_sel = 2'd3;
        cyc(4'b0111, 4'b0111, 1'b1, 4'b0000, "fp_oob1");
        cyc(4'b0111, 4'b0111, 1'b1, 4'b0000, "fp_oob2");
        force_en = 1'b0;
        cyc(4'h0, 4'h0, 1'b1, 4'b0000, "fp_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
